// File: rtl/csr_access_ctrl.sv
// CSR read-modify-write initiator: one request at a time through IDLE/READ/WRITE/RESP.
// Optional privilege and read-only checks are enabled by defining CSR_ACC_PRIV_CHECK_EN.
module csr_access_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk_free,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_operand,
  input  logic            req_wen,
  input  logic [1:0]      req_priv,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_illegal,
  output logic            csr_wr,
  output logic [11:0]     csr_waddr,
  output logic [11:0]     csr_raddr,
  output logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] csr_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_t;

  state_t          state_reg, state_next;
  logic [11:0]     addr_reg;
  logic [1:0]      op_reg;
  logic [XLEN-1:0] operand_reg;
  logic            wen_reg;
  logic            illegal_reg, illegal_next;
  logic [XLEN-1:0] old_reg;
  logic [XLEN-1:0] new_reg, new_next;
  logic            req_fire;
  logic            rsp_fire;

  assign req_fire = req_valid && req_ready;
  assign rsp_fire = rsp_valid && rsp_ready;

  // Legality is decided once, from the live request fields at acceptance.
  always_comb begin
    illegal_next = (req_op == 2'b00);
`ifdef CSR_ACC_PRIV_CHECK_EN
    if (req_addr[9:8] > req_priv) begin
      illegal_next = 1'b1;
    end
    if ((req_addr[11:10] == 2'b11) && req_wen) begin
      illegal_next = 1'b1;
    end
`endif
  end

`ifndef CSR_ACC_PRIV_CHECK_EN
  logic unused_priv;
  assign unused_priv = ^req_priv;
`endif

  // Per-bit modify step, applied to the value read this cycle.
  genvar gi;
  generate
    for (gi = 0; gi < XLEN; gi++) begin : g_rmw
      assign new_next[gi] = (op_reg == 2'b01) ? operand_reg[gi] :
                            (op_reg == 2'b10) ? (csr_rdata[gi] | operand_reg[gi]) :
                            (op_reg == 2'b11) ? (csr_rdata[gi] & ~operand_reg[gi]) :
                                                csr_rdata[gi];
    end
  endgenerate

  always_ff @(posedge clk_free or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (req_fire) state_next = READ;
      READ:    state_next = WRITE;
      WRITE:   state_next = RESP;
      RESP:    if (rsp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_rdata   = '0;
    rsp_illegal = 1'b0;
    csr_wr      = 1'b0;
    unique case (state_reg)
      IDLE:  req_ready = 1'b1;
      READ:  ;
      WRITE: csr_wr = wen_reg && !illegal_reg;
      RESP: begin
        rsp_valid   = 1'b1;
        rsp_rdata   = old_reg;
        rsp_illegal = illegal_reg;
      end
      default: ;
    endcase
  end

  // Old value is zeroed at capture for illegal requests so RESP just forwards it.
  always_ff @(posedge clk_free or posedge rst) begin
    if (rst) begin
      addr_reg    <= '0;
      op_reg      <= '0;
      operand_reg <= '0;
      wen_reg     <= 1'b0;
      illegal_reg <= 1'b0;
      old_reg     <= '0;
      new_reg     <= '0;
    end else begin
      if (req_fire) begin
        addr_reg    <= req_addr;
        op_reg      <= req_op;
        operand_reg <= req_operand;
        wen_reg     <= req_wen;
        illegal_reg <= illegal_next;
      end
      if (state_reg == READ) begin
        old_reg <= illegal_reg ? '0 : csr_rdata;
        new_reg <= new_next;
      end
    end
  end

  assign csr_raddr = addr_reg;
  assign csr_waddr = addr_reg;
  assign csr_wdata = new_reg;

endmodule
